// File: rtl/sprime_block_fetch_p.sv
// sprime_block_fetch_p: parametrised ping-pong S' block fetcher.
// Reads BLK x BLK signed samples from SRAM into one DPRAM0 half.
// Ports: start/restart control; busy/done/mem_end/bank status;
//        blk_plane/row/col walk position; SRAM read port;
//        dp_write_* DPRAM0 write port ({wbank, k} address).
module sprime_block_fetch_p #(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int BLK_LOG2 = 3,
  parameter int SRAM_LAT = 2,
  parameter int Y_BASE   = 76800,
  parameter int U_BASE   = 153600,
  parameter int V_BASE   = 192000,
  localparam int DP_AW   = 2*BLK_LOG2+1
) (
  input  logic             CLOCK_50_I,
  input  logic             Resetn,
  input  logic             start,
  input  logic             restart,
  output logic             busy,
  output logic             done,
  output logic             mem_end,
  output logic             bank,
  output logic [1:0]       blk_plane,
  output logic [7:0]       blk_row,
  output logic [7:0]       blk_col,
  output logic [17:0]      SRAM_address,
  input  logic [15:0]      SRAM_read_data,
  output logic [31:0]      dp_write_data,
  output logic [DP_AW-1:0] dp_write_address,
  output logic             dp_write_enable
);

  localparam int BLK  = 1 << BLK_LOG2;
  localparam int KW   = 2*BLK_LOG2;
  localparam int DW   = $clog2(SRAM_LAT+1);
  localparam int Y_CM = IMG_W/BLK - 1;
  localparam int C_CM = IMG_W/(2*BLK) - 1;
  localparam int R_M  = IMG_H/BLK - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [KW:0]       r_k;
  logic [DW-1:0]     r_d;
  logic              r_bank;
  logic              r_mem_end;
  logic [1:0]        r_plane;
  logic [7:0]        r_row;
  logic [7:0]        r_col;
  logic [17:0]       r_addr;
  logic [SRAM_LAT:0] r_pv;
  logic [DP_AW-1:0]  r_pa [SRAM_LAT+1];

  logic              w_accept;
  logic              w_more;
  logic              w_issue;
  logic              w_last;
  logic              w_fin;
  logic [KW-1:0]     w_kidx;
  logic [BLK_LOG2-1:0] w_r;
  logic [BLK_LOG2-1:0] w_c;
  logic [17:0]       w_base;
  logic [17:0]       w_stride;
  logic [17:0]       w_addr;
  logic [7:0]        w_cmax;

  // IDLE and FINISH both accept a new start, which is what
  // gives the 67-cycle back-to-back period.
  assign w_accept = (r_state == S_IDLE || r_state == S_FINISH)
                  && start && !r_mem_end && !restart;
  // r_k is the index of the next address; its MSB marks all N issued.
  assign w_more   = (r_state == S_FETCH) && !r_k[KW] && !restart;
  assign w_issue  = w_accept || w_more;
  assign w_last   = (r_d == DW'(SRAM_LAT-1));
  assign w_fin    = (r_state == S_DRAIN) && w_last && !restart;

  assign w_kidx = (r_state == S_FETCH) ? r_k[KW-1:0] : '0;
  assign w_r    = w_kidx[KW-1:BLK_LOG2];
  assign w_c    = w_kidx[BLK_LOG2-1:0];

  assign w_base = (r_plane == 2'd0) ? 18'(Y_BASE) :
                  (r_plane == 2'd1) ? 18'(U_BASE) :
                                      18'(V_BASE);
  assign w_stride = (r_plane == 2'd0) ? 18'(IMG_W)
                                      : 18'(IMG_W/2);
  assign w_cmax   = (r_plane == 2'd0) ? 8'(Y_CM) : 8'(C_CM);

  // blk_row*BLK + r and blk_col*BLK + c are plain concatenations.
  assign w_addr = w_base
                + 18'({r_row, w_r}) * w_stride
                + 18'({r_col, w_c});

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE,
      S_FINISH: w_next = w_accept ? S_FETCH : S_IDLE;
      S_FETCH:  if (r_k[KW]) w_next = S_DRAIN;
      S_DRAIN:  if (w_last)  w_next = S_FINISH;
      default:  w_next = S_IDLE;
    endcase
    if (restart) w_next = S_IDLE;
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_k    <= '0;
      r_d    <= '0;
      r_addr <= '0;
    end else begin
      r_d <= (r_state == S_DRAIN) ? r_d + DW'(1) : '0;
      if (w_issue) begin
        r_addr <= w_addr;
        r_k    <= (r_state == S_FETCH) ? r_k + (KW+1)'(1)
                                       : (KW+1)'(1);
      end
    end
  end

  // Walk position; the last V block parks the walk and sets mem_end.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_bank    <= 1'b1;
      r_mem_end <= 1'b0;
      r_plane   <= 2'd0;
      r_row     <= 8'd0;
      r_col     <= 8'd0;
    end else if (restart) begin
      r_bank    <= 1'b1;
      r_mem_end <= 1'b0;
      r_plane   <= 2'd0;
      r_row     <= 8'd0;
      r_col     <= 8'd0;
    end else if (w_fin) begin
      r_bank <= ~r_bank;
      if (r_col != w_cmax) begin
        r_col <= r_col + 8'd1;
      end else if (r_row != 8'(R_M)) begin
        r_col <= 8'd0;
        r_row <= r_row + 8'd1;
      end else if (r_plane != 2'd2) begin
        r_col   <= 8'd0;
        r_row   <= 8'd0;
        r_plane <= r_plane + 2'd1;
      end else begin
        r_mem_end <= 1'b1;
      end
    end
  end

  // Stage 0 lines up with SRAM_address; stage SRAM_LAT with the data.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_pv <= '0;
      for (int i = 0; i <= SRAM_LAT; i++) r_pa[i] <= '0;
    end else begin
      if (restart) r_pv <= '0;
      else         r_pv <= {r_pv[SRAM_LAT-1:0], w_issue};
      r_pa[0] <= {~r_bank, w_kidx};
      for (int i = 1; i <= SRAM_LAT; i++) r_pa[i] <= r_pa[i-1];
    end
  end

  assign busy             = (r_state == S_FETCH) ||
                            (r_state == S_DRAIN);
  assign done             = (r_state == S_FINISH);
  assign mem_end          = r_mem_end;
  assign bank             = r_bank;
  assign blk_plane        = r_plane;
  assign blk_row          = r_row;
  assign blk_col          = r_col;
  assign SRAM_address     = r_addr;
  assign dp_write_data    = {{16{SRAM_read_data[15]}},
                             SRAM_read_data};
  assign dp_write_address = r_pa[SRAM_LAT];
  assign dp_write_enable  = r_pv[SRAM_LAT];

endmodule
